fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Control stage directly upstream of the execute-stage 4:1 operand muxes (24-bit datapath).
- Tracks destination registers of in-flight instructions in a 3-entry shadow pipeline (EX, MEM, WB).
- Drives the registered 2-bit select for operand muxes A and B.
- Raises load-use stall, honours global hold and flush, and counts stall cycles.

Parameters:
- REG_ADDR_W, 4, width of register specifiers
- ZERO_REG, 1, 1 = register 0 is hardwired and never forwarded or stalled on
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  decode stage holds a valid instruction
- id_rs1  input  REG_ADDR_W  source register A of decoding instruction
- id_rs2  input  REG_ADDR_W  source register B
- id_rd  input  REG_ADDR_W  destination register
- id_we  input  1  instruction writes id_rd
- id_load  input  1  instruction is a load
- hold  input  1  global freeze (memory wait)
- flush  input  1  kill the instruction entering EX
- sel_a  output  2  operand A mux select for instruction in EX
- sel_b  output  2  operand B mux select
- ex_valid  output  1  EX entry is a real instruction (not a bubble)
- stall  output  1  load-use stall; decode and fetch must hold
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding (shared package): 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB result, 11 = retired-writeback holding register.
- Each entry (ex_q, mem_q, wb_q) holds {valid, rd, we, load}.
- A producer "matches" a source when its valid and we are both 1 and its rd equals the source. When ZERO_REG=1, a source of 0 never matches.
- Reset: all entries cleared, so all valid = 0.
- Reset values: sel_a = sel_b = 00, ex_valid = 0, stall = 0, stall_cnt = 0.
- stall is combinational: id_valid & ex_q.valid & ex_q.load & ex_q.we & (id_rs1 or id_rs2 matches ex_q.rd).
- Select computation, at decode, per source: ex_q match gives 01, else mem_q match gives 10, else wb_q match gives 11, else 00. The youngest producer wins.
- Per clock edge with hold = 0:
  - mem_q <= ex_q and wb_q <= mem_q.
  - If flush or stall or !id_valid: ex_q <= bubble and sel_a/sel_b <= 00.
  - Otherwise: ex_q <= {1, id_rd, id_we, id_load} and sel_a/sel_b <= the computed selects.
- ex_valid = ex_q.valid, registered; latency 1 cycle from decode to selects.
- hold = 1: every register (entries, selects, counter) is frozen. hold has priority over flush and stall.
- Upstream must keep flush asserted until hold drops.
- stall plus flush in the same cycle: a bubble is inserted either way. stall_cnt still increments because stall is high.
- stall_cnt increments by 1 on every non-hold edge with stall = 1 and saturates at all-ones (no wrap).
- A load-use stall lasts exactly one cycle. After one bubble the load sits in MEM and is forwarded with select 10.
- Reset mid-operation: all state clears immediately (asynchronous). Instructions in flight are discarded with no partial update.

Decomposition:
- Package fwd_pkg holds:
  - the select enum FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WBH=2'b11;
  - the packed struct pipe_ent_t {valid, rd, we, load}.
- One natural sub-module, fwd_sel_calc: combinational priority select for one source operand. Instantiate it twice (A, B).

Test Plan:
- Back-to-back ALU dependency: issue r3 <= ... then an instruction with rs1 = 3. Required: the second instruction's EX cycle shows sel_a = 01, sel_b = 00, stall never asserted.
- Distance 2 and 3: producer of r5, then an independent instruction, then a consumer with rs2 = 5 gives sel_b = 10. Repeat with two independent instructions in between: sel_b = 11.
- Load-use: a load writing r2 followed by a consumer with rs1 = 2. Required:
  - stall = 1 for exactly one cycle;
  - ex_valid = 0 on the next cycle (bubble);
  - the consumer then enters with sel_a = 10;
  - stall_cnt = 1.
- Zero register and priority:
  - producers of r0 with a consumer of r0 give select 00 and no stall.
  - two producers of r4 back-to-back, then a consumer of r4, give select 01 (youngest wins).
- Hold/flush:
  - assert hold for 3 cycles mid-stream: sel, ex_valid and stall_cnt are unchanged throughout.
  - flush with hold low gives ex_valid = 0 and sels = 00 on the next cycle, while mem_q/wb_q still advance and forwarding of the older producers is intact.
- Saturation and reset: with CNT_W = 2, force 5 load-use stalls and stall_cnt stops at 3. Assert rst asynchronously mid-stall: all outputs drop to 0 before the next clock edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard control slice: operand-mux select
// encoding and the shadow-pipeline entry tracked per in-flight instruction.
package fwd_pkg;

  // Widest register specifier an entry can carry. The instantiating module's
  // REG_ADDR_W must not exceed this; specifiers are zero-extended into it.
  localparam int RD_MAX_W = 8;

  // Execute-stage 4:1 operand mux select encoding.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register file read data
    FWD_EXMEM = 2'b01,  // EX/MEM ALU result
    FWD_MEMWB = 2'b10,  // MEM/WB result
    FWD_WBH   = 2'b11   // retired-writeback holding register
  } fwd_sel_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                load;
  } pipe_ent_t;

  localparam pipe_ent_t PIPE_BUBBLE = '0;

  // A producer matches a source when it is a real, register-writing
  // instruction whose destination equals that source.
  function automatic logic ent_match(input pipe_ent_t ent,
                                     input logic [RD_MAX_W-1:0] src);
    return ent.valid && ent.we && (ent.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority forwarding select for a single source operand. The youngest
// matching producer (EX, then MEM, then WB) wins; otherwise the register file.
module fwd_sel_calc
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  pipe_ent_t             ex_ent,
  input  pipe_ent_t             mem_ent,
  input  pipe_ent_t             wb_ent,
  output fwd_sel_e              sel,
  output logic                  ex_hit
);

  logic [RD_MAX_W-1:0] src_ext;
  logic                src_live;
  logic                mem_hit;
  logic                wb_hit;

  assign src_ext = RD_MAX_W'(src);

  // A hardwired zero register is never a dependency, so it masks all matches.
  assign src_live = !(ZERO_REG && (src == '0));

  // Per-stage match detection, gated by whether the source can depend at all.
  always_comb begin
    ex_hit  = src_live && ent_match(ex_ent, src_ext);
    mem_hit = src_live && ent_match(mem_ent, src_ext);
    wb_hit  = src_live && ent_match(wb_ent, src_ext);
  end

  // Youngest-producer-first priority encode onto the mux select.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else if (wb_hit) begin
      sel = FWD_WBH;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for the execute-stage operand muxes.
// Shadows the destination registers of the instructions in EX, MEM and WB,
// registers the operand selects one cycle ahead of EX, raises the load-use
// stall, and counts stall cycles with a saturating counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_load,
  input  logic                  hold,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  ex_valid,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_ent_t  ex_q;
  pipe_ent_t  mem_q;
  pipe_ent_t  wb_q;

  fwd_sel_e   sel_a_d;
  fwd_sel_e   sel_b_d;
  logic       ex_hit_a;
  logic       ex_hit_b;
  logic       issue_bubble;
  pipe_ent_t  id_ent;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

  fwd_sel_calc #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_sel_a (
    .src     (id_rs1),
    .ex_ent  (ex_q),
    .mem_ent (mem_q),
    .wb_ent  (wb_q),
    .sel     (sel_a_d),
    .ex_hit  (ex_hit_a)
  );

  fwd_sel_calc #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_sel_b (
    .src     (id_rs2),
    .ex_ent  (ex_q),
    .mem_ent (mem_q),
    .wb_ent  (wb_q),
    .sel     (sel_b_d),
    .ex_hit  (ex_hit_b)
  );

  // Load-use hazard: a load in EX cannot forward its data yet, so a decoding
  // consumer must wait one cycle until the load reaches MEM.
  always_comb begin
    stall = id_valid && ex_q.valid && ex_q.load && ex_q.we &&
            (ex_hit_a || ex_hit_b);
  end

  // Decide what enters EX: the decoding instruction or a bubble.
  always_comb begin
    issue_bubble = flush || stall || !id_valid;
    id_ent       = PIPE_BUBBLE;
    id_ent.valid = 1'b1;
    id_ent.rd    = RD_MAX_W'(id_rd);
    id_ent.we    = id_we;
    id_ent.load  = id_load;
  end

  // ---- stage boundary: decode -> EX/MEM/WB shadow entries and selects ----
  // Shadow pipeline advance and registered selects; hold freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= PIPE_BUBBLE;
      mem_q <= PIPE_BUBBLE;
      wb_q  <= PIPE_BUBBLE;
      sel_a <= FWD_RF;
      sel_b <= FWD_RF;
    end else if (!hold) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (issue_bubble) begin
        ex_q  <= PIPE_BUBBLE;
        sel_a <= FWD_RF;
        sel_b <= FWD_RF;
      end else begin
        ex_q  <= id_ent;
        sel_a <= sel_a_d;
        sel_b <= sel_b_d;
      end
    end
  end

  // Saturating stall-cycle counter, frozen while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!hold && stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign ex_valid = ex_q.valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. The DUT uses a 2-bit stall counter so
// saturation is reachable quickly; every other behaviour is width-independent.
module tb_fwd_hazard_unit;

  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 2;

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic                  id_load;
  logic                  hold;
  logic                  flush;
  logic [1:0]            sel_a;
  logic [1:0]            sel_b;
  logic                  ex_valid;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cnt;

  int n_vec;
  int n_err;
  int exp_cnt;

  fwd_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_load   (id_load),
    .hold      (hold),
    .flush     (flush),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ex_valid  (ex_valid),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction at decode (call just after an active edge).
  task automatic issue(input logic v, input int rs1, input int rs2, input int rd,
                       input logic we, input logic ld);
    id_valid = v;
    id_rs1   = REG_ADDR_W'(rs1);
    id_rs2   = REG_ADDR_W'(rs2);
    id_rd    = REG_ADDR_W'(rd);
    id_we    = we;
    id_load  = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [1:0] a,
                        input logic [1:0] b);
    chk({tag, "_exv"}, 32'(ex_valid), 32'(v));
    chk({tag, "_sela"}, 32'(sel_a), 32'(a));
    chk({tag, "_selb"}, 32'(sel_b), 32'(b));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_ex("rst", 1'b0, 2'b00, 2'b00);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    rst = 1'b0;
    tick();
    exp_cnt = 0;

    // Back-to-back ALU dependency: r3 producer then rs1 = 3.
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0);
    chk("b2b_p_stall", 32'(stall), 0);
    tick();
    chk_ex("b2b_p", 1'b1, 2'b00, 2'b00);
    issue(1'b1, 3, 6, 7, 1'b1, 1'b0);
    chk("b2b_c_stall", 32'(stall), 0);
    tick();
    chk_ex("b2b_c", 1'b1, 2'b01, 2'b00);
    idle(3);

    // Distance 2: producer r5, independent, consumer rs2 = 5.
    issue(1'b1, 1, 2, 5, 1'b1, 1'b0); tick();
    issue(1'b1, 9, 10, 8, 1'b1, 1'b0); tick();
    issue(1'b1, 11, 5, 12, 1'b1, 1'b0); tick();
    chk_ex("dist2", 1'b1, 2'b00, 2'b10);
    idle(3);

    // Distance 3: two independents between producer and consumer.
    issue(1'b1, 1, 2, 5, 1'b1, 1'b0); tick();
    issue(1'b1, 9, 10, 8, 1'b1, 1'b0); tick();
    issue(1'b1, 10, 11, 9, 1'b1, 1'b0); tick();
    issue(1'b1, 13, 5, 12, 1'b1, 1'b0); tick();
    chk_ex("dist3", 1'b1, 2'b00, 2'b11);
    idle(3);

    // Load-use: load r2 then rs1 = 2 -> one stall, one bubble, then 10.
    issue(1'b1, 10, 11, 2, 1'b1, 1'b1); tick();
    issue(1'b1, 2, 13, 14, 1'b1, 1'b0);
    chk("lu_stall_on", 32'(stall), 1);
    tick();
    exp_cnt = 1;
    chk("lu_bubble_exv", 32'(ex_valid), 0);
    chk("lu_stall_off", 32'(stall), 0);
    chk("lu_cnt", 32'(stall_cnt), 32'(exp_cnt));
    tick();
    chk_ex("lu_fwd", 1'b1, 2'b10, 2'b00);
    idle(3);
    chk("lu_cnt_after", 32'(stall_cnt), 32'(exp_cnt));

    // Zero register: load of r0 then consumer of r0 -> no stall, select 00.
    issue(1'b1, 1, 2, 0, 1'b1, 1'b1); tick();
    issue(1'b1, 0, 0, 1, 1'b1, 1'b0);
    chk("zero_stall", 32'(stall), 0);
    tick();
    chk_ex("zero", 1'b1, 2'b00, 2'b00);
    idle(3);

    // Priority: two producers of r4, consumer of r4 on both sources.
    issue(1'b1, 1, 2, 4, 1'b1, 1'b0); tick();
    issue(1'b1, 1, 2, 4, 1'b1, 1'b0); tick();
    issue(1'b1, 4, 4, 6, 1'b1, 1'b0); tick();
    chk_ex("prio", 1'b1, 2'b01, 2'b01);
    idle(3);

    // Hold with a load-use pending: everything frozen for 3 cycles.
    issue(1'b1, 1, 2, 6, 1'b1, 1'b1); tick();
    hold = 1'b1;
    issue(1'b1, 6, 1, 7, 1'b1, 1'b0);
    chk("hold_stall", 32'(stall), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ex("hold", 1'b1, 2'b00, 2'b00);
      chk("hold_cnt", 32'(stall_cnt), 32'(exp_cnt));
    end
    hold = 1'b0;
    tick();
    exp_cnt = 2;
    chk("unhold_exv", 32'(ex_valid), 0);
    chk("unhold_cnt", 32'(stall_cnt), 32'(exp_cnt));
    tick();
    chk_ex("unhold_fwd", 1'b1, 2'b10, 2'b00);
    idle(3);

    // Flush: bubble enters EX while older producers keep advancing.
    issue(1'b1, 1, 2, 3, 1'b1, 1'b0); tick();
    issue(1'b1, 1, 2, 5, 1'b1, 1'b0); tick();
    flush = 1'b1;
    issue(1'b1, 3, 5, 9, 1'b1, 1'b0); tick();
    flush = 1'b0;
    chk_ex("flush", 1'b0, 2'b00, 2'b00);
    issue(1'b1, 3, 5, 10, 1'b1, 1'b0); tick();
    chk_ex("post_flush", 1'b1, 2'b11, 2'b10);
    idle(3);

    // Saturation: five more load-use stalls, counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
      issue(1'b1, 3, 2, 7, 1'b1, 1'b0);
      chk("sat_stall", 32'(stall), 1);
      tick();
      if (exp_cnt < 3) exp_cnt++;
      chk("sat_cnt", 32'(stall_cnt), 32'(exp_cnt));
      idle(3);
    end

    // Asynchronous reset in the middle of a stall cycle.
    issue(1'b1, 1, 2, 2, 1'b1, 1'b1); tick();
    issue(1'b1, 2, 3, 7, 1'b1, 1'b0);
    chk("ar_stall_pre", 32'(stall), 1);
    #1;
    rst = 1'b1;
    #1;
    chk_ex("ar", 1'b0, 2'b00, 2'b00);
    chk("ar_stall", 32'(stall), 0);
    chk("ar_cnt", 32'(stall_cnt), 0);
    tick();
    rst = 1'b0;
    idle(1);
    chk_ex("ar_after", 1'b0, 2'b00, 2'b00);
    chk("ar_after_cnt", 32'(stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
